// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch port (I)
//   and the data-access port (D). Each access holds the memory for LAT
//   cycles (BUSY), then pulses the owner's ready for one cycle (DONE).
//   D normally wins a tie; after MAX_SKIP consecutive D wins with I waiting,
//   I is forced through so fetch cannot starve.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   i_req/i_addr            fetch request (held until i_ready)
//   i_rdata/i_ready         fetch result word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request (held until d_ready)
//   d_rdata/d_ready         load result word, one-cycle completion pulse
//   stall_f/stall_m         pipeline stall requests (combinational)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory-side interface
module mem_port_arbiter #(
    parameter int LAT      = 2,
    parameter int MAX_SKIP = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        stall_f,
    output logic        stall_m,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(LAT) + 1;
    localparam int SW = $clog2(MAX_SKIP) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] skip_q, skip_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic skip_sat;
    logic grant_d, grant_i;

    // Grants are only ever made from IDLE; D loses a tie only once I has
    // been passed over MAX_SKIP times in a row.
    assign skip_sat = (skip_q == SW'(MAX_SKIP));
    assign grant_d  = (state_q == S_IDLE) && d_req && (!i_req || !skip_sat);
    assign grant_i  = (state_q == S_IDLE) && i_req && !grant_d;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        skip_d    = skip_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    owner_d = OWN_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    cnt_d   = CW'(LAT - 1);
                    state_d = S_BUSY;
                    // Only a D win that actually bypassed a waiting I counts.
                    if (i_req && !skip_sat) skip_d = skip_q + SW'(1);
                end else if (grant_i) begin
                    owner_d = OWN_I;
                    we_d    = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    cnt_d   = CW'(LAT - 1);
                    state_d = S_BUSY;
                    skip_d  = '0;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    // mem_rdata is valid in the last BUSY cycle only.
                    if (!we_q) begin
                        if (owner_q == OWN_D) d_rdata_d = mem_rdata;
                        else                  i_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_I;
            cnt_q     <= '0;
            skip_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            skip_q    <= skip_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_ready   = (state_q == S_DONE) && (owner_q == OWN_I);
    assign d_ready   = (state_q == S_DONE) && (owner_q == OWN_D);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_f   = i_req && !i_ready;
    assign stall_m   = d_req && !d_ready;

    // Memory side is quiet (all zero) outside BUSY.
    assign mem_en    = (state_q == S_BUSY);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;

    // LAT=2 instance
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ready, d_ready, stall_f, stall_m, mem_en, mem_we;

    // LAT=1 instance
    logic        i_req1, d_req1, d_we1;
    logic [31:0] i_addr1, d_addr1, d_wdata1, mem_rdata1;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic        i_ready1, d_ready1, stall_f1, stall_m1, mem_en1, mem_we1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LAT(2), .MAX_SKIP(3)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.LAT(1), .MAX_SKIP(3)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ready(i_ready1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_ready(d_ready1),
        .stall_f(stall_f1), .stall_m(stall_m1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] order;
        logic [7:0] exp_order;
        int         n;
        logic       prev_en;
        logic       seen;

        reset = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        i_req1 = 0; i_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0; mem_rdata1 = 0;
        step(); step();

        // Reset state
        chk("rst_mem_en",  32'(mem_en),  0);
        chk("rst_mem_we",  32'(mem_we),  0);
        chk("rst_mem_addr", mem_addr,    0);
        chk("rst_i_ready", 32'(i_ready), 0);
        chk("rst_d_ready", 32'(d_ready), 0);
        chk("rst_i_rdata", i_rdata,      0);
        chk("rst_d_rdata", d_rdata,      0);

        // 1: single fetch
        reset = 0;
        i_req = 1; i_addr = 32'h0; mem_rdata = 32'h00500113;
        #1;
        chk("t1_stall_f_t0", 32'(stall_f), 1);
        chk("t1_mem_en_t0",  32'(mem_en),  0);
        step();
        chk("t1_mem_en_t1",  32'(mem_en),  1);
        chk("t1_mem_we_t1",  32'(mem_we),  0);
        chk("t1_stall_f_t1", 32'(stall_f), 1);
        step();
        chk("t1_mem_en_t2",  32'(mem_en),  1);
        chk("t1_stall_f_t2", 32'(stall_f), 1);
        step();
        chk("t1_i_ready",    32'(i_ready), 1);
        chk("t1_i_rdata",    i_rdata,      32'h00500113);
        chk("t1_stall_f_t3", 32'(stall_f), 0);
        chk("t1_mem_en_t3",  32'(mem_en),  0);
        i_req = 0;
        step();

        // 2: same-cycle requests, D wins, I follows
        i_req = 1; i_addr = 32'h4;
        d_req = 1; d_we = 1; d_addr = 100; d_wdata = 25;
        mem_rdata = 32'h11111111;
        #1;
        chk("t2_stall_m_t0", 32'(stall_m), 1);
        step();
        chk("t2_mem_we_t1",    32'(mem_we), 1);
        chk("t2_mem_addr_t1",  mem_addr,    100);
        chk("t2_mem_wdata_t1", mem_wdata,   25);
        step();
        chk("t2_mem_addr_t2",  mem_addr,    100);
        step();
        chk("t2_d_ready", 32'(d_ready), 1);
        chk("t2_i_ready", 32'(i_ready), 0);
        chk("t2_d_rdata", d_rdata,      0);
        d_req = 0; d_we = 0;
        step();
        chk("t2_mem_en_t4", 32'(mem_en), 0);
        step();
        chk("t2_mem_addr_t5", mem_addr,    4);
        chk("t2_mem_we_t5",   32'(mem_we), 0);
        step();
        step();
        chk("t2_i_ready_t7", 32'(i_ready), 1);
        chk("t2_i_rdata",    i_rdata,      32'h11111111);
        chk("t2_d_rdata_t7", d_rdata,      0);
        i_req = 0;
        step();

        // 3: starvation bound, both held continuously
        i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 200;
        order = '0; n = 0; prev_en = 1'b0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            step();
            if (mem_en && !prev_en) begin
                order[n] = (mem_addr == 200);
                n++;
            end
            prev_en = mem_en;
        end
        chk("t3_grant_count", n, 8);
        exp_order = 8'b0111_0111;
        for (int k = 0; k < 8; k++)
            chk($sformatf("t3_grant%0d_is_d", k), 32'(order[k]), 32'(exp_order[k]));
        d_req = 0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            seen = i_ready;
        end
        chk("t3_final_i_ready", 32'(seen), 1);
        i_req = 0;
        step();

        // 5: reset in second BUSY cycle of a D write
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55;
        step();
        chk("t5_mem_we_t1", 32'(mem_we), 1);
        step();
        chk("t5_mem_en_t2", 32'(mem_en), 1);
        reset = 1;
        step();
        chk("t5_mem_en_after",  32'(mem_en),  0);
        chk("t5_mem_we_after",  32'(mem_we),  0);
        chk("t5_mem_addr_after", mem_addr,    0);
        reset = 0; d_req = 0; d_we = 0;
        i_req = 1; i_addr = 32'h123;
        seen = d_ready;
        step();
        seen = seen | d_ready;
        chk("t5_i_grant_en",   32'(mem_en), 1);
        chk("t5_i_grant_addr", mem_addr,    32'h123);
        mem_rdata = 32'h0;
        step();
        seen = seen | d_ready;
        step();
        seen = seen | d_ready;
        chk("t5_no_d_ready", 32'(seen),    0);
        chk("t5_i_ready",    32'(i_ready), 1);
        i_req = 0;
        step();

        // 6: request changed/dropped while BUSY
        d_req = 1; d_we = 0; d_addr = 32'h80; mem_rdata = 32'hCAFEF00D;
        step();
        d_addr = 32'h84;
        #1;
        chk("t6_mem_addr_t1", mem_addr, 32'h80);
        step();
        d_req = 0;
        #1;
        chk("t6_stall_m_drop", 32'(stall_m), 0);
        chk("t6_mem_addr_t2",  mem_addr,     32'h80);
        d_req = 1;
        #1;
        chk("t6_stall_m_raise", 32'(stall_m), 1);
        step();
        chk("t6_d_ready",  32'(d_ready), 1);
        chk("t6_stall_m",  32'(stall_m), 0);
        chk("t6_d_rdata",  d_rdata,      32'hCAFEF00D);
        d_req = 0;
        step();

        // 4: LAT=1 load
        d_req1 = 1; d_we1 = 0; d_addr1 = 96; mem_rdata1 = 32'hDEADBEEF;
        step();
        chk("t4_mem_en_t1",   32'(mem_en1), 1);
        chk("t4_mem_addr_t1", mem_addr1,    96);
        step();
        chk("t4_d_ready_t2",  32'(d_ready1), 1);
        chk("t4_d_rdata_t2",  d_rdata1,      32'hDEADBEEF);
        chk("t4_mem_en_t2",   32'(mem_en1),  0);
        step();
        chk("t4_idle_t3",     32'(mem_en1),  0);
        step();
        chk("t4_regrant_t4",  32'(mem_en1),  1);
        step();
        chk("t4_d_ready_t5",  32'(d_ready1), 1);
        d_req1 = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
